// File: rtl/h264_cavlc_pkg.sv
// rtl/h264_cavlc_pkg.sv - shared CAVLC types and block-size constants
package h264_cavlc_pkg;

    // Expander control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int COEFF_W_DEF    = 8;
    localparam int MAX_COEFF_LUMA = 16;
    localparam int MAX_COEFF_AC   = 15;
    localparam int MAX_COEFF_CDC  = 4;

    // Physical buffer depth; smaller block types use the low entries only
    localparam int BUF_DEPTH      = 16;

endpackage

// File: rtl/coeff_run_expander.sv
// rtl/coeff_run_expander.sv - rebuilds a scan-ordered coefficient block from CAVLC level/run pairs
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   blk_start, total_coeff_i,
//   total_zeros_i                 block parameter load (IDLE only)
//   lvl_valid/lvl_ready,
//   lvl_i, run_before_i           level/run pairs, highest frequency first
//   coeff_valid/coeff_ready,
//   coeff_o, coeff_idx_o,
//   coeff_last                    scan-order output stream, index 0 first
//   busy                          block in progress
//   err                           sticky syntax error, cleared on next block load
module coeff_run_expander
    import h264_cavlc_pkg::*;
#(
    parameter int COEFF_W   = COEFF_W_DEF,
    parameter int MAX_COEFF = MAX_COEFF_LUMA
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blk_start,
    input  logic [4:0]         total_coeff_i,
    input  logic [3:0]         total_zeros_i,
    input  logic               lvl_valid,
    output logic               lvl_ready,
    input  logic [COEFF_W-1:0] lvl_i,
    input  logic [3:0]         run_before_i,
    output logic               coeff_valid,
    input  logic               coeff_ready,
    output logic [COEFF_W-1:0] coeff_o,
    output logic [3:0]         coeff_idx_o,
    output logic               coeff_last,
    output logic               busy,
    output logic               err
);

    state_t             state;
    state_t             state_next;
    logic [COEFF_W-1:0] buffer [BUF_DEPTH];
    logic [4:0]         pos;
    logic [4:0]         zeros_left;
    logic [4:0]         remaining;
    logic [3:0]         idx;

    logic [5:0]         sum;
    logic [4:0]         run;
    logic               run_err;
    logic               load_err;
    logic               take_lvl;
    logic               take_coeff;

    always_comb begin
        state_next  = state;
        lvl_ready   = 1'b0;
        coeff_valid = 1'b0;
        coeff_o     = '0;
        coeff_idx_o = '0;
        coeff_last  = 1'b0;
        busy        = (state != IDLE);
        run         = '0;
        run_err     = 1'b0;
        load_err    = 1'b0;
        take_lvl    = 1'b0;
        take_coeff  = 1'b0;
        sum         = {1'b0, total_coeff_i} + {2'b00, total_zeros_i};

        case (state)
            IDLE: begin
                if (blk_start) begin
                    if (total_coeff_i == 5'd0) begin
                        state_next = DRAIN;
                    end else if (total_coeff_i > 5'(MAX_COEFF) || sum > 6'(MAX_COEFF)) begin
                        load_err   = 1'b1;
                        state_next = DRAIN;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                lvl_ready = 1'b1;
                if (lvl_valid) begin
                    take_lvl = 1'b1;
                    // The last level absorbs whatever zeros are left; once the
                    // zero budget is spent, run_before carries no information.
                    if (remaining == 5'd1) begin
                        run = zeros_left;
                    end else if (zeros_left == 5'd0) begin
                        run = '0;
                    end else if ({1'b0, run_before_i} > zeros_left) begin
                        run_err = 1'b1;
                        run     = zeros_left;
                    end else begin
                        run = {1'b0, run_before_i};
                    end
                    if (remaining == 5'd1) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                coeff_valid = 1'b1;
                coeff_o     = buffer[idx];
                coeff_idx_o = idx;
                coeff_last  = (idx == 4'(MAX_COEFF - 1));
                if (coeff_ready) begin
                    take_coeff = 1'b1;
                    if (coeff_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            pos        <= '0;
            zeros_left <= '0;
            remaining  <= '0;
            idx        <= '0;
            err        <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (state == IDLE && blk_start) begin
                for (int i = 0; i < BUF_DEPTH; i++) begin
                    buffer[i] <= '0;
                end
                err        <= load_err;
                pos        <= 5'(sum - 6'd1);
                zeros_left <= {1'b0, total_zeros_i};
                remaining  <= total_coeff_i;
                idx        <= '0;
            end
            if (take_lvl) begin
                buffer[pos[3:0]] <= lvl_i;
                remaining        <= remaining - 5'd1;
                zeros_left       <= zeros_left - run;
                pos              <= pos - 5'd1 - run;
                if (run_err) begin
                    err <= 1'b1;
                end
            end
            if (take_coeff) begin
                idx <= coeff_last ? 4'd0 : idx + 4'd1;
            end
        end
    end

    // Writes must land inside the block and the next position must not wrap
    always @(posedge clk) begin
        if (rst && take_lvl) begin
            assert (pos >= run && pos < 5'(MAX_COEFF));
        end
    end

endmodule
